// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a one-word skid buffer.
//
// Issues one instruction-memory request per cycle from the program counter
// and registers the returned word into the IF/ID outputs. When the pipeline
// stalls while a word is arriving, that word is parked in a skid buffer. When
// the stall releases, the parked word goes out next.
//
// Redirect from execute (jump_flag) has top priority. It flushes the skid
// buffer and any response arriving on the same edge.
//
// Optional interrupt entry is compiled in when the macro FETCH_INT_EN is
// defined. Without it, int_req/int_ret are ignored and int_ack/int_epc read 0.
//
// Parameters
//   CPU_WIDTH   instruction / PC / data width
//   RST_ADDR    PC after reset
//   INT_VECTOR  PC loaded on interrupt entry
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   hold_flag           pipeline stall (also freezes IF/ID)
//   jump_flag/addr      redirect request and target
//   int_req, int_ret    interrupt request (level), handler-return pulse
//   int_ack, int_epc    entry pulse, captured return address
//   imem_req/addr       memory request and fetch address (= pc)
//   imem_ready/rdata    memory response handshake and data
//   IF_inst_data/pc/valid  registered instruction, its address, valid flag
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int                   CPU_WIDTH  = 16,
    parameter logic [CPU_WIDTH-1:0] RST_ADDR   = {CPU_WIDTH{1'b0}},
    parameter logic [CPU_WIDTH-1:0] INT_VECTOR = 16'h0004
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold_flag,
    input  logic                 jump_flag,
    input  logic [CPU_WIDTH-1:0] jump_addr,
    input  logic                 int_req,
    input  logic                 int_ret,
    output logic                 int_ack,
    output logic [CPU_WIDTH-1:0] int_epc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic [CPU_WIDTH-1:0] IF_inst_data,
    output logic [CPU_WIDTH-1:0] IF_pc,
    output logic                 IF_valid
);

    localparam logic S_REQ  = 1'b0;
    localparam logic S_SKID = 1'b1;

    localparam logic [CPU_WIDTH-1:0] ZERO_W = {CPU_WIDTH{1'b0}};
    localparam logic [CPU_WIDTH-1:0] ONE_W  = {{(CPU_WIDTH-1){1'b0}}, 1'b1};

    logic                 state_q,   state_d;
    logic [CPU_WIDTH-1:0] pc_q,      pc_d;
    logic [CPU_WIDTH-1:0] skid_q,    skid_d;
    logic [CPU_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [CPU_WIDTH-1:0] inst_q,    inst_d;
    logic [CPU_WIDTH-1:0] if_pc_q,   if_pc_d;
    logic                 valid_q,   valid_d;
    logic                 int_entry_s;
    logic [CPU_WIDTH-1:0] pc_inc_s;

    // Wraps naturally modulo 2^CPU_WIDTH.
    assign pc_inc_s = pc_q + ONE_W;

`ifdef FETCH_INT_EN
    logic                 int_busy_q, int_busy_d;
    logic                 int_ack_q,  int_ack_d;
    logic [CPU_WIDTH-1:0] int_epc_q,  int_epc_d;

    // Entry is blocked by a same-edge int_ret, so a return and a new request
    // on one edge defer entry to the following edge.
    // Interrupt entry decision.
    always_comb begin
        int_entry_s = (state_q == S_REQ) && int_req && !int_busy_q && !int_ret
                      && !jump_flag && !hold_flag;
    end

    // Interrupt bookkeeping next-state.
    always_comb begin
        int_ack_d  = 1'b0;
        int_epc_d  = int_epc_q;
        int_busy_d = int_busy_q;
        if (int_ret) begin
            int_busy_d = 1'b0;
        end else if (int_entry_s) begin
            int_busy_d = 1'b1;
            int_ack_d  = 1'b1;
            int_epc_d  = pc_q;
        end else begin
            int_busy_d = int_busy_q;
        end
    end

    // Interrupt bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_busy_q <= 1'b0;
            int_ack_q  <= 1'b0;
            int_epc_q  <= ZERO_W;
        end else begin
            int_busy_q <= int_busy_d;
            int_ack_q  <= int_ack_d;
            int_epc_q  <= int_epc_d;
        end
    end

    assign int_ack = int_ack_q;
    assign int_epc = int_epc_q;
`else
    // Interrupt pins stay on the boundary but have no effect in this build.
    logic unused_int_s;
    assign unused_int_s = ^{int_req, int_ret, INT_VECTOR};
    assign int_entry_s  = 1'b0;
    assign int_ack      = 1'b0;
    assign int_epc      = ZERO_W;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; redirect and interrupt entry always return to S_REQ.
    always_comb begin
        state_d = state_q;
        if (jump_flag || int_entry_s) begin
            state_d = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready && hold_flag) begin
                        state_d = S_SKID;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_SKID: begin
                    if (!hold_flag) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_SKID;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // FSM output logic: a request is in flight only in S_REQ and never in reset.
    always_comb begin
        if (rst) begin
            imem_req = 1'b0;
        end else if (state_q == S_REQ) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    assign imem_addr = pc_q;

    // Datapath next-state: pc, skid buffer and IF/ID outputs.
    always_comb begin
        pc_d      = pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        inst_d    = inst_q;
        if_pc_d   = if_pc_q;
        valid_d   = valid_q;
        if (jump_flag) begin
            // Flush: drop the skid word and any response on this edge.
            pc_d      = jump_addr;
            skid_d    = ZERO_W;
            skid_pc_d = ZERO_W;
            inst_d    = ZERO_W;
            valid_d   = 1'b0;
        end else if (int_entry_s) begin
            pc_d    = INT_VECTOR;
            inst_d  = ZERO_W;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready && !hold_flag) begin
                        inst_d  = imem_rdata;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc_s;
                    end else if (imem_ready) begin
                        // Stalled while the word arrives: park it.
                        skid_d    = imem_rdata;
                        skid_pc_d = pc_q;
                        pc_d      = pc_inc_s;
                    end else if (!hold_flag) begin
                        inst_d  = ZERO_W;
                        valid_d = 1'b0;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                S_SKID: begin
                    if (!hold_flag) begin
                        inst_d  = skid_q;
                        if_pc_d = skid_pc_q;
                        valid_d = 1'b1;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RST_ADDR;
            skid_q    <= ZERO_W;
            skid_pc_q <= ZERO_W;
            inst_q    <= ZERO_W;
            if_pc_q   <= ZERO_W;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
            inst_q    <= inst_d;
            if_pc_q   <= if_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign IF_inst_data = inst_q;
    assign IF_pc        = if_pc_q;
    assign IF_valid     = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed, self-checking bench for if_fetch.
// Memory model: zero-wait (when imem_ready=1), data = address ^ data_xor.
// Expected values for interrupt behaviour depend on FETCH_INT_EN.
// ---------------------------------------------------------------------------
module tb_if_fetch;

`ifdef FETCH_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        hold_flag;
    logic        jump_flag;
    logic [15:0] jump_addr;
    logic        int_req;
    logic        int_ret;
    logic        int_ack;
    logic [15:0] int_epc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] IF_inst_data;
    logic [15:0] IF_pc;
    logic        IF_valid;
    logic [15:0] data_xor;

    int n_checks;
    int n_errors;

    if_fetch #(
        .CPU_WIDTH (16),
        .RST_ADDR  (16'h0000),
        .INT_VECTOR(16'h0004)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold_flag   (hold_flag),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .int_req     (int_req),
        .int_ret     (int_ret),
        .int_ack     (int_ack),
        .int_epc     (int_epc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .IF_inst_data(IF_inst_data),
        .IF_pc       (IF_pc),
        .IF_valid    (IF_valid)
    );

    assign imem_rdata = imem_addr ^ data_xor;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the IF/ID output triple.
    task automatic chk_out(input string tag, input logic v, input logic [15:0] pc,
                           input logic [15:0] inst);
        chk({tag, ".valid"}, {15'd0, IF_valid}, {15'd0, v});
        chk({tag, ".pc"}, IF_pc, pc);
        chk({tag, ".inst"}, IF_inst_data, inst);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        hold_flag  = 1'b0;
        jump_flag  = 1'b0;
        jump_addr  = 16'h0000;
        int_req    = 1'b0;
        int_ret    = 1'b0;
        imem_ready = 1'b1;
        data_xor   = 16'h0000;

        // Reset state.
        step();
        chk("rst.req", {15'd0, imem_req}, 16'h0000);
        chk("rst.addr", imem_addr, 16'h0000);
        chk_out("rst", 1'b0, 16'h0000, 16'h0000);
        chk("rst.ack", {15'd0, int_ack}, 16'h0000);
        chk("rst.epc", int_epc, 16'h0000);
        rst = 1'b0;
        #1;
        chk("rel.req", {15'd0, imem_req}, 16'h0001);

        // Zero-wait stream 0,1,2,3 with data = address.
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("stream", 1'b1, 16'(i), 16'(i));
        end

        // Distinguish data from address from here on.
        data_xor = 16'h5A00;
        step();
        chk_out("w4", 1'b1, 16'h0004, 16'h5A04);
        chk("w4.addr", imem_addr, 16'h0005);

        // Stall 3 cycles while word 5 arrives: buffered, outputs frozen.
        hold_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("hold", 1'b1, 16'h0004, 16'h5A04);
            chk("hold.req", {15'd0, imem_req}, 16'h0000);
        end
        chk("hold.addr", imem_addr, 16'h0006);
        hold_flag = 1'b0;
        step();
        chk_out("skid5", 1'b1, 16'h0005, 16'h5A05);
        chk("skid5.req", {15'd0, imem_req}, 16'h0001);
        step();
        chk_out("w6", 1'b1, 16'h0006, 16'h5A06);

        // Memory not ready without hold: bubble, IF_pc kept, address stable.
        imem_ready = 1'b0;
        step();
        chk_out("bubble", 1'b0, 16'h0006, 16'h0000);
        chk("bubble.addr", imem_addr, 16'h0007);
        imem_ready = 1'b1;
        step();
        chk_out("w7", 1'b1, 16'h0007, 16'h5A07);

        // Enter S_SKID with word 8, then jump during hold.
        hold_flag = 1'b1;
        step();
        chk("skid8.req", {15'd0, imem_req}, 16'h0000);
        jump_flag = 1'b1;
        jump_addr = 16'h0040;
        step();
        chk_out("jskid", 1'b0, 16'h0007, 16'h0000);
        chk("jskid.addr", imem_addr, 16'h0040);
        chk("jskid.req", {15'd0, imem_req}, 16'h0001);
        jump_flag = 1'b0;
        hold_flag = 1'b0;
        step();
        chk_out("w40", 1'b1, 16'h0040, 16'h5A40);

        // PC wrap at all-ones.
        jump_flag = 1'b1;
        jump_addr = 16'hFFFF;
        step();
        chk("jff.addr", imem_addr, 16'hFFFF);
        jump_flag = 1'b0;
        step();
        chk_out("wff", 1'b1, 16'hFFFF, 16'hA5FF);
        chk("wrap.addr", imem_addr, 16'h0000);

        // Interrupt at pc = 0x0010.
        jump_flag = 1'b1;
        jump_addr = 16'h0010;
        step();
        jump_flag = 1'b0;
        int_req   = 1'b1;
        step();
        chk("i1.ack", {15'd0, int_ack}, INT_EN ? 16'h0001 : 16'h0000);
        chk("i1.epc", int_epc, INT_EN ? 16'h0010 : 16'h0000);
        chk("i1.addr", imem_addr, INT_EN ? 16'h0004 : 16'h0011);
        chk("i1.valid", {15'd0, IF_valid}, INT_EN ? 16'h0000 : 16'h0001);
        step();
        chk("i2.ack", {15'd0, int_ack}, 16'h0000);
        chk("i2.pc", IF_pc, INT_EN ? 16'h0004 : 16'h0011);
        step();
        chk("i3.ack", {15'd0, int_ack}, 16'h0000);
        // Return and request on the same edge: no entry on this edge.
        int_ret = 1'b1;
        step();
        chk("i4.ack", {15'd0, int_ack}, 16'h0000);
        chk("i4.addr", imem_addr, INT_EN ? 16'h0007 : 16'h0014);
        int_ret = 1'b0;
        step();
        chk("i5.ack", {15'd0, int_ack}, INT_EN ? 16'h0001 : 16'h0000);
        chk("i5.epc", int_epc, INT_EN ? 16'h0007 : 16'h0000);
        chk("i5.addr", imem_addr, INT_EN ? 16'h0004 : 16'h0015);
        int_req = 1'b0;
        int_ret = 1'b1;
        step();
        chk("i6.ack", {15'd0, int_ack}, 16'h0000);
        int_ret = 1'b0;

        // Jump and interrupt on the same edge: jump wins, entry next edge.
        jump_flag = 1'b1;
        jump_addr = 16'h0020;
        int_req   = 1'b1;
        step();
        chk("ji1.ack", {15'd0, int_ack}, 16'h0000);
        chk("ji1.addr", imem_addr, 16'h0020);
        chk("ji1.valid", {15'd0, IF_valid}, 16'h0000);
        jump_flag = 1'b0;
        step();
        chk("ji2.ack", {15'd0, int_ack}, INT_EN ? 16'h0001 : 16'h0000);
        chk("ji2.epc", int_epc, INT_EN ? 16'h0020 : 16'h0000);
        chk("ji2.addr", imem_addr, INT_EN ? 16'h0004 : 16'h0021);
        int_req = 1'b0;
        step();
        chk("ji3.ack", {15'd0, int_ack}, 16'h0000);

        // Reset while in S_SKID abandons the buffered word.
        hold_flag = 1'b1;
        step();
        chk("rs.req", {15'd0, imem_req}, 16'h0000);
        rst = 1'b1;
        #1;
        chk("rs.addr", imem_addr, 16'h0000);
        chk("rs.valid", {15'd0, IF_valid}, 16'h0000);
        chk("rs.epc", int_epc, 16'h0000);
        hold_flag = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("rs.req1", {15'd0, imem_req}, 16'h0001);
        step();
        chk_out("rs.w0", 1'b1, 16'h0000, 16'h5A00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
